// File: rtl/credit_stream_receiver.sv
// Credit-flow receive buffer: pushes arrive without backpressure,
// each pop returns one credit to the transmitter on the next cycle.
module credit_stream_receiver #(
  parameter type         T        = logic,
  parameter int unsigned Depth    = 4,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                src_valid_i,
  input  T                    src_data_i,
  output logic                credit_o,
  output logic                dst_valid_o,
  input  logic                dst_ready_i,
  output T                    dst_data_o,
  output logic [CntWidth-1:0] fill_o,
  output logic                overflow_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_credit;
  logic          r_ovf;
  T              r_mem [Depth];

  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_ridx;
  logic [AW:0]   w_fill;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_hit;

  assign w_widx = r_wptr[AW-1:0];
  assign w_ridx = r_rptr[AW-1:0];

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_widx == w_ridx) &&
                   (r_wptr[AW] != r_rptr[AW]);

  // Fullness is judged before any same-cycle pop frees a slot.
  assign w_push    = src_valid_i && !w_full;
  assign w_ovf_hit = src_valid_i && w_full;
  assign w_pop     = !w_empty && dst_ready_i;

  assign w_fill = r_wptr - r_rptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      r_credit <= w_pop;
      r_ovf    <= r_ovf | w_ovf_hit;
    end
  end

  // Storage is deliberately left unreset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[w_widx] <= src_data_i;
    end
  end

  assign dst_valid_o = !w_empty;
  assign dst_data_o  = r_mem[w_ridx];
  assign fill_o      = CntWidth'(w_fill);
  assign credit_o    = r_credit;
  assign overflow_o  = r_ovf;

endmodule
